// File: rtl/ls11_test_sequencer_pkg.sv
// Shared types and constants for the 74LS11 tester. Optional build macro used by the top:
// LS11_STOP_ON_FAIL_EN.
package ls11_test_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned NumVectors = 8;
  localparam int unsigned VecW       = $clog2(NumVectors);
  localparam logic [VecW-1:0] LastVec = 3'b111;

  // A 3-input AND is high only when every input is high.
  function automatic logic [2:0] expected_y(logic [VecW-1:0] vec);
    return {3{vec == LastVec}};
  endfunction

endpackage

// File: rtl/ls11_test_sequencer_settle_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module ls11_test_sequencer_settle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ls11_test_sequencer.sv
// Exhaustive sequencer for a 74LS11 triple 3-input AND. Define LS11_STOP_ON_FAIL_EN to end a
// run at the first mismatching vector instead of applying all eight.
module ls11_test_sequencer
  import ls11_test_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] a_o,
  output logic [2:0] b_o,
  output logic [2:0] c_o,
  input  logic [2:0] y_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_mask,
  output logic [2:0] first_fail_vec
);

  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [VecW-1:0] vec_q, vec_d;
  logic            pass_q, pass_d;
  logic [2:0]      fail_mask_q, fail_mask_d;
  logic [2:0]      first_fail_q, first_fail_d;
  logic            timer_load, timer_en, timer_zero;
  logic [2:0]      mism;
  logic            last_step;

  ls11_test_sequencer_settle_timer #(
    .CNT_W (CNT_W)
  ) u_settle_timer (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (timer_load),
    .load_val_i (SettleLoad),
    .en_i       (timer_en),
    .zero_o     (timer_zero)
  );

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    pass_d       = pass_q;
    fail_mask_d  = fail_mask_q;
    first_fail_d = first_fail_q;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
    last_step    = 1'b0;
    mism         = y_i ^ expected_y(vec_q);

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StSettle;
          vec_d        = '0;
          timer_load   = 1'b1;
          pass_d       = 1'b0;
          fail_mask_d  = '0;
          first_fail_d = '0;
        end
      end
      StSettle: begin
        if (timer_zero) begin
          state_d = StSample;
        end else begin
          timer_en = 1'b1;
        end
      end
      StSample: begin
        fail_mask_d = fail_mask_q | mism;
        // Only the very first mismatching vector of the run is recorded.
        if ((mism != '0) && (fail_mask_q == '0)) begin
          first_fail_d = vec_q;
        end
        last_step = (vec_q == LastVec);
`ifdef LS11_STOP_ON_FAIL_EN
        if (mism != '0) begin
          last_step = 1'b1;
        end
`endif
        if (last_step) begin
          state_d = StDone;
          vec_d   = '0;
          pass_d  = (fail_mask_d == '0);
        end else begin
          state_d    = StSettle;
          vec_d      = vec_q + 1'b1;
          timer_load = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        vec_d   = '0;
      end
      default: begin
        state_d = StIdle;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      pass_q       <= 1'b0;
      fail_mask_q  <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      pass_q       <= pass_d;
      fail_mask_q  <= fail_mask_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign a_o            = {3{vec_q[2]}};
  assign b_o            = {3{vec_q[1]}};
  assign c_o            = {3{vec_q[0]}};
  assign busy           = (state_q == StSettle) || (state_q == StSample);
  assign done           = (state_q == StDone);
  assign pass           = pass_q;
  assign fail_mask      = fail_mask_q;
  assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_ls11_test_sequencer.sv
// Scoreboard bench: two sequencers (settle 4 and settle 1) each driving a delayed AND-gate model.
module tb_ls11_test_sequencer;

`ifdef LS11_STOP_ON_FAIL_EN
  localparam int SA1Lat = 5;
`else
  localparam int SA1Lat = 40;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start_f;
  logic [2:0] a, b, c, y, af, bf, cf, yf;
  logic       busy, done, pass, busy_f, done_f, pass_f;
  logic [2:0] fm, ffv, fm_f, ffv_f;

  // Device models: one pipeline stage per 10 ns of propagation delay.
  logic [2:0] d1 = '0, d2 = '0, d3 = '0, f1 = '0, f2 = '0, f3 = '0;
  int         dev_delay = 1;
  logic [2:0] sa0 = '0, sa1 = '0;
  always @(posedge clk) begin
    d1 <= a & b & c;
    d2 <= d1;
    d3 <= d2;
    f1 <= af & bf & cf;
    f2 <= f1;
    f3 <= f2;
  end
  assign y  = (((dev_delay == 3) ? d3 : d1) & ~sa0) | sa1;
  assign yf = f3;

  ls11_test_sequencer #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a_o(a), .b_o(b), .c_o(c), .y_i(y),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fm), .first_fail_vec(ffv)
  );

  ls11_test_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut_fast (
    .clk(clk), .reset(reset), .start(start_f), .a_o(af), .b_o(bf), .c_o(cf), .y_i(yf),
    .busy(busy_f), .done(done_f), .pass(pass_f), .fail_mask(fm_f), .first_fail_vec(ffv_f)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       pass;
    logic [2:0] fm;
    logic [2:0] ffv;
    int         cyc;
  } exp_t;

  exp_t q_main[$];
  exp_t q_fast[$];
  int   checks = 0;
  int   failures = 0;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (q_main.size() == 0) begin
        check("main_unexpected_done", cyc, -1);
      end else begin
        e = q_main.pop_front();
        check("main_done_cycle", cyc, e.cyc);
        check("main_pass", int'(pass), int'(e.pass));
        check("main_fail_mask", int'(fm), int'(e.fm));
        check("main_first_fail_vec", int'(ffv), int'(e.ffv));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done_f) begin
      if (q_fast.size() == 0) begin
        check("fast_unexpected_done", cyc, -1);
      end else begin
        e = q_fast.pop_front();
        check("fast_done_cycle", cyc, e.cyc);
        check("fast_pass", int'(pass_f), int'(e.pass));
        check("fast_fail_mask", int'(fm_f), int'(e.fm));
        check("fast_first_fail_vec", int'(ffv_f), int'(e.ffv));
      end
    end
  end

  // s is the cycle count seen just after the edge that sampled start.
  task automatic kick(output int s);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    s = cyc;
  endtask

  task automatic push_main(input logic p, input logic [2:0] m, input logic [2:0] f, input int dc);
    exp_t e;
    e.pass = p; e.fm = m; e.ffv = f; e.cyc = dc;
    q_main.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (q_main.size() != 0 || q_fast.size() != 0); i++) @(negedge clk);
    check(name, q_main.size() + q_fast.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, bad;
    exp_t e;
    reset = 1'b1; start = 1'b0; start_f = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_main_outputs", int'({a, b, c, busy, done, pass, fm, ffv}), 0);
    check("reset_fast_outputs", int'({af, bf, cf, busy_f, done_f, pass_f, fm_f, ffv_f}), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: good device, busy window and held results
    kick(s);
    push_main(1'b1, 3'b000, 3'b000, s + 40);
    bad = 0;
    for (int k = 0; k <= 40; k++) begin
      if (busy != ((cyc - s) <= 39)) bad++;
      @(negedge clk);
    end
    check("t1_busy_window", bad, 0);
    drain("t1_drain");
    repeat (5) @(negedge clk);
    check("t1_results_held", int'({busy, pass, fm, ffv}), int'({1'b0, 1'b1, 6'b0}));

    // 2: gate 2 stuck-at-0
    sa0 = 3'b010;
    kick(s);
    push_main(1'b0, 3'b010, 3'b111, s + 40);
    drain("t2_drain");
    repeat (3) @(negedge clk);
    check("t2_results_held", int'({pass, fm, ffv}), int'({1'b0, 3'b010, 3'b111}));
    sa0 = 3'b000;

    // 3: gate 1 stuck-at-1
    sa1 = 3'b001;
    kick(s);
    push_main(1'b0, 3'b001, 3'b000, s + SA1Lat);
    drain("t3_drain");
    sa1 = 3'b000;

    // 4: reset mid-run aborts with no done pulse
    kick(s);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t4_reset_outputs", int'({a, b, c, busy, done, pass, fm, ffv}), 0);
    reset = 1'b0;
    kick(s);
    push_main(1'b1, 3'b000, 3'b000, s + 40);
    drain("t4_drain");

    // 5: start re-pulsed while busy is ignored
    kick(s);
    push_main(1'b1, 3'b000, 3'b000, s + 40);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    drain("t5_drain");
    repeat (45) @(negedge clk);
    check("t5_no_restart_busy", int'(busy), 0);

    // 6: slow device (30 ns) against settle 1 and settle 4
    dev_delay = 3;
    kick(s);
    push_main(1'b1, 3'b000, 3'b000, s + 40);
    @(negedge clk) start_f = 1'b1;
    @(negedge clk) start_f = 1'b0;
    e.pass = 1'b0; e.fm = 3'b111; e.ffv = 3'b111; e.cyc = cyc + 16;
    q_fast.push_back(e);
    drain("t6_drain");
    dev_delay = 1;

    // 7: start held high gives back-to-back runs
    @(negedge clk) start = 1'b1;
    @(negedge clk) s = cyc;
    push_main(1'b1, 3'b000, 3'b000, s + 40);
    push_main(1'b1, 3'b000, 3'b000, s + 82);
    repeat (60) @(negedge clk);
    start = 1'b0;
    drain("t7_drain");
    repeat (3) @(negedge clk);
    check("t7_idle_after", int'({busy, done}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
